// File: rtl/afe_pkg.sv
// Shared constants and FSM encoding for the analog front-end measurement sequencer.
// Measure_Sel codes match the HC595 driver's selection decode.
package afe_pkg;

   localparam logic [3:0] MEAS_VX  = 4'd0;
   localparam logic [3:0] MEAS_VR  = 4'd1;
   localparam logic [3:0] MEAS_LP  = 4'd2;
   localparam logic [3:0] MEAS_LC  = 4'd3;
   localparam logic [3:0] MEAS_GND = 4'd6;

   // Clocks the HC595 driver needs to refresh its whole shift chain once.
   localparam int HC595_FRAME_CLKS = 68;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_APPLY    = 3'd1,
      ST_SETTLE   = 3'd2,
      ST_ACQ_WAIT = 3'd3,
      ST_NEXT     = 3'd4,
      ST_PARK     = 3'd5
   } state_t;

endpackage

// File: rtl/afe_lowest_bit_sel.sv
// Picks the lowest enabled measurement step from a 4-bit step mask.
// valid is low when no step remains.
module afe_lowest_bit_sel
   import afe_pkg::*;
(
   input  logic [3:0] mask,
   output logic [1:0] idx,
   output logic       valid
);

   always_comb begin
      idx   = MEAS_VX[1:0];
      valid = |mask;
      if (mask[0])      idx = MEAS_VX[1:0];
      else if (mask[1]) idx = MEAS_VR[1:0];
      else if (mask[2]) idx = MEAS_LP[1:0];
      else if (mask[3]) idx = MEAS_LC[1:0];
   end

endmodule

// File: rtl/afe_meas_sequencer.sv
// Steps the analog front end through the enabled measurement selections, waits for settling,
// and requests one ADC acquisition per step before parking the front end on GND.
module afe_meas_sequencer
   import afe_pkg::*;
#(
   parameter int SETTLE_CYCLES = 500000,
   parameter int ACQ_TIMEOUT   = 1000000,
   parameter int CNT_W         = 21
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_start,
   input  logic       i_abort,
   input  logic [3:0] i_step_mask,
   input  logic [2:0] i_rr_sel,
   input  logic [1:0] i_vr_sel,
   input  logic       i_bias_on,
   input  logic       i_acq_done,
   output logic [3:0] o_CTRL_Measure_Sel,
   output logic [2:0] o_CTRL_Rr_Sel,
   output logic [1:0] o_CTRL_Vr_Sel,
   output logic       o_CTRL_Bias_ON,
   output logic       o_CTRL_Vx_Vr_AMP,
   output logic       o_acq_req,
   output logic [1:0] o_step_idx,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_err,
   output state_t     o_state
);

   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] ACQ_LOAD    = CNT_W'(ACQ_TIMEOUT - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [3:0]       work_mask;
   logic [2:0]       rr_lat;
   logic [1:0]       vr_lat;
   logic             bias_lat;
   logic [3:0]       mask_clr;
   logic [3:0]       sel_in;
   logic [1:0]       lb_idx;
   logic             lb_valid;

   // IDLE looks at the incoming mask, NEXT at the working mask minus the step just finished.
   assign mask_clr = work_mask & ~(4'b0001 << o_step_idx);
   assign sel_in   = (state == ST_IDLE) ? i_step_mask : mask_clr;

   afe_lowest_bit_sel u_lowest_bit_sel (
      .mask  (sel_in),
      .idx   (lb_idx),
      .valid (lb_valid)
   );

   assign o_CTRL_Vx_Vr_AMP = 1'b1;
   assign o_busy           = (state != ST_IDLE);
   assign o_state          = state;

   // Acquisition handshake: o_acq_req is a level held from ACQ_WAIT entry; a single-cycle
   // i_acq_done while req is high completes it and req drops on the following edge. done
   // outside ACQ_WAIT is ignored, and i_abort withdraws req on the same edge.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state              <= ST_IDLE;
         cnt                <= '0;
         work_mask          <= '0;
         rr_lat             <= '0;
         vr_lat             <= '0;
         bias_lat           <= 1'b0;
         o_CTRL_Measure_Sel <= MEAS_GND;
         o_CTRL_Rr_Sel      <= '0;
         o_CTRL_Vr_Sel      <= '0;
         o_CTRL_Bias_ON     <= 1'b0;
         o_acq_req          <= 1'b0;
         o_step_idx         <= '0;
         o_done             <= 1'b0;
         o_err              <= 1'b0;
      end else begin
         o_done <= 1'b0;
         if (i_abort && state != ST_IDLE) begin
            o_acq_req          <= 1'b0;
            o_CTRL_Measure_Sel <= MEAS_GND;
            o_CTRL_Bias_ON     <= 1'b0;
            cnt                <= SETTLE_LOAD;
            state              <= ST_PARK;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (i_start) begin
                     work_mask <= i_step_mask;
                     rr_lat    <= i_rr_sel;
                     vr_lat    <= i_vr_sel;
                     bias_lat  <= i_bias_on;
                     o_err     <= 1'b0;
                     if (lb_valid) begin
                        o_step_idx         <= lb_idx;
                        o_CTRL_Measure_Sel <= {2'b00, lb_idx};
                        o_CTRL_Rr_Sel      <= i_rr_sel;
                        o_CTRL_Vr_Sel      <= i_vr_sel;
                        o_CTRL_Bias_ON     <= i_bias_on;
                        state              <= ST_APPLY;
                     end else begin
                        o_done <= 1'b1;
                     end
                  end
               end
               ST_APPLY: begin
                  cnt   <= SETTLE_LOAD;
                  state <= ST_SETTLE;
               end
               ST_SETTLE: begin
                  if (cnt == '0) begin
                     o_acq_req <= 1'b1;
                     cnt       <= ACQ_LOAD;
                     state     <= ST_ACQ_WAIT;
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
               ST_ACQ_WAIT: begin
                  if (i_acq_done) begin
                     o_acq_req <= 1'b0;
                     state     <= ST_NEXT;
                  end else if (cnt == '0) begin
                     o_err              <= 1'b1;
                     o_acq_req          <= 1'b0;
                     o_CTRL_Measure_Sel <= MEAS_GND;
                     o_CTRL_Bias_ON     <= 1'b0;
                     cnt                <= SETTLE_LOAD;
                     state              <= ST_PARK;
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
               ST_NEXT: begin
                  work_mask <= mask_clr;
                  if (lb_valid) begin
                     o_step_idx         <= lb_idx;
                     o_CTRL_Measure_Sel <= {2'b00, lb_idx};
                     o_CTRL_Rr_Sel      <= rr_lat;
                     o_CTRL_Vr_Sel      <= vr_lat;
                     o_CTRL_Bias_ON     <= bias_lat;
                     state              <= ST_APPLY;
                  end else begin
                     o_done             <= 1'b1;
                     o_CTRL_Measure_Sel <= MEAS_GND;
                     o_CTRL_Bias_ON     <= 1'b0;
                     cnt                <= SETTLE_LOAD;
                     state              <= ST_PARK;
                  end
               end
               ST_PARK: begin
                  // The GND image must also settle before another sequence may start.
                  if (cnt == '0) state <= ST_IDLE;
                  else           cnt   <= cnt - 1'b1;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_afe_meas_sequencer.sv
// Directed bench for afe_meas_sequencer with short settle/timeout values.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_afe_meas_sequencer;
   import afe_pkg::*;

   localparam int SETTLE = 200;
   localparam int ACQ_TO = 1000;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [3:0] step_mask = '0;
   logic [2:0] rr_sel = '0;
   logic [1:0] vr_sel = '0;
   logic       bias_on = 1'b0;
   logic       acq_done = 1'b0;

   logic [3:0] meas_sel_o;
   logic [2:0] rr_sel_o;
   logic [1:0] vr_sel_o;
   logic       bias_on_o;
   logic       amp_o;
   logic       acq_req_o;
   logic [1:0] step_idx_o;
   logic       busy_o;
   logic       done_o;
   logic       err_o;
   state_t     state_o;

   int   n_vec = 0;
   int   n_err = 0;
   int   done_cnt = 0;
   int   req_rise = 0;
   logic req_q = 1'b0;
   int   c;
   int   d0;
   int   r0;

   always #5 clk = ~clk;

   afe_meas_sequencer #(
      .SETTLE_CYCLES (SETTLE),
      .ACQ_TIMEOUT   (ACQ_TO),
      .CNT_W         (21)
   ) dut (
      .i_clk              (clk),
      .i_rst_n            (rst_n),
      .i_start            (start),
      .i_abort            (abort),
      .i_step_mask        (step_mask),
      .i_rr_sel           (rr_sel),
      .i_vr_sel           (vr_sel),
      .i_bias_on          (bias_on),
      .i_acq_done         (acq_done),
      .o_CTRL_Measure_Sel (meas_sel_o),
      .o_CTRL_Rr_Sel      (rr_sel_o),
      .o_CTRL_Vr_Sel      (vr_sel_o),
      .o_CTRL_Bias_ON     (bias_on_o),
      .o_CTRL_Vx_Vr_AMP   (amp_o),
      .o_acq_req          (acq_req_o),
      .o_step_idx         (step_idx_o),
      .o_busy             (busy_o),
      .o_done             (done_o),
      .o_err              (err_o),
      .o_state            (state_o)
   );

   // Event monitors: o_done pulses and rising edges of o_acq_req.
   always @(negedge clk) begin
      if (done_o === 1'b1) done_cnt <= done_cnt + 1;
      if (acq_req_o === 1'b1 && req_q !== 1'b1) req_rise <= req_rise + 1;
      req_q <= acq_req_o;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic start_seq(input logic [3:0] m, input logic [2:0] rr, input logic [1:0] vr,
                            input logic b);
      step_mask = m;
      rr_sel    = rr;
      vr_sel    = vr;
      bias_on   = b;
      start     = 1'b1;
      @(negedge clk);
      start     = 1'b0;
   endtask

   task automatic wait_req(output int cyc);
      cyc = 0;
      while (acq_req_o !== 1'b1 && cyc < 400) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic wait_idle(output int cyc);
      cyc = 0;
      while (busy_o !== 1'b0 && cyc < 400) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   // Entered at the falling edge right after APPLY entry; leaves right after the next APPLY/PARK entry.
   task automatic do_acq(input logic [1:0] idx, input logic [2:0] rr);
      int cyc;
      wait_req(cyc);
      check("req_latency", cyc, SETTLE + 1);
      check("idx_at_req", step_idx_o, idx);
      check("sel_at_req", meas_sel_o, {2'b00, idx});
      check("rr_at_req", rr_sel_o, rr);
      tick(10);
      acq_done = 1'b1;
      check("req_held", acq_req_o, 1'b1);
      @(negedge clk);
      acq_done = 1'b0;
      check("req_drop", acq_req_o, 1'b0);
      @(negedge clk);
   endtask

   initial begin
      // Reset values
      tick(2);
      check("rst_sel", meas_sel_o, MEAS_GND);
      check("rst_rr", rr_sel_o, 0);
      check("rst_vr", vr_sel_o, 0);
      check("rst_bias", bias_on_o, 0);
      check("rst_amp", amp_o, 1);
      check("rst_req", acq_req_o, 0);
      check("rst_idx", step_idx_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_done", done_o, 0);
      check("rst_err", err_o, 0);
      check("rst_state", state_o, ST_IDLE);
      rst_n = 1'b1;
      tick(2);

      // 1: steps Vx then Vr
      d0 = done_cnt;
      r0 = req_rise;
      start_seq(4'b0011, 3'd2, 2'd1, 1'b1);
      check("t1_state_apply", state_o, ST_APPLY);
      check("t1_sel0", meas_sel_o, MEAS_VX);
      check("t1_busy", busy_o, 1);
      check("t1_vr", vr_sel_o, 1);
      check("t1_bias", bias_on_o, 1);
      do_acq(2'd0, 3'd2);
      check("t1_sel1", meas_sel_o, MEAS_VR);
      check("t1_done_mid", done_o, 0);
      do_acq(2'd1, 3'd2);
      check("t1_done_pulse", done_o, 1);
      check("t1_park_sel", meas_sel_o, MEAS_GND);
      check("t1_park_bias", bias_on_o, 0);
      check("t1_park_state", state_o, ST_PARK);
      check("t1_park_busy", busy_o, 1);
      wait_idle(c);
      check("t1_park_len", c, SETTLE);
      check("t1_done_count", done_cnt - d0, 1);
      check("t1_req_count", req_rise - r0, 2);
      check("t1_err", err_o, 0);
      tick(2);

      // 2: steps Vr then Lc only
      d0 = done_cnt;
      r0 = req_rise;
      start_seq(4'b1010, 3'd5, 2'd2, 1'b0);
      check("t2_sel1", meas_sel_o, MEAS_VR);
      check("t2_idx1", step_idx_o, 1);
      do_acq(2'd1, 3'd5);
      check("t2_sel3", meas_sel_o, MEAS_LC);
      check("t2_idx3", step_idx_o, 3);
      do_acq(2'd3, 3'd5);
      check("t2_done_pulse", done_o, 1);
      wait_idle(c);
      check("t2_park_len", c, SETTLE);
      check("t2_done_count", done_cnt - d0, 1);
      check("t2_req_count", req_rise - r0, 2);
      tick(2);

      // 3: empty mask
      d0 = done_cnt;
      r0 = req_rise;
      start_seq(4'b0000, 3'd1, 2'd1, 1'b1);
      check("t3_done", done_o, 1);
      check("t3_busy", busy_o, 0);
      check("t3_state", state_o, ST_IDLE);
      check("t3_idx_kept", step_idx_o, 3);
      check("t3_sel", meas_sel_o, MEAS_GND);
      @(negedge clk);
      check("t3_done_end", done_o, 0);
      tick(5);
      check("t3_done_count", done_cnt - d0, 1);
      check("t3_req_count", req_rise - r0, 0);

      // 4: acquisition timeout, then err cleared by next start
      d0 = done_cnt;
      start_seq(4'b0001, 3'd0, 2'd0, 1'b0);
      wait_req(c);
      check("t4_req_latency", c, SETTLE + 1);
      c = 0;
      while (err_o !== 1'b1 && c < 1200) begin
         @(negedge clk);
         c++;
      end
      check("t4_err_time", c, ACQ_TO);
      check("t4_req_drop", acq_req_o, 0);
      check("t4_park_sel", meas_sel_o, MEAS_GND);
      check("t4_park_state", state_o, ST_PARK);
      wait_idle(c);
      check("t4_park_len", c, SETTLE);
      check("t4_err_sticky", err_o, 1);
      check("t4_no_done", done_cnt - d0, 0);
      start_seq(4'b0000, 3'd0, 2'd0, 1'b0);
      check("t4_err_clear", err_o, 0);
      check("t4_empty_done", done_o, 1);
      tick(2);

      // 5a: spurious done/start during SETTLE, then abort
      d0 = done_cnt;
      r0 = req_rise;
      start_seq(4'b0001, 3'd1, 2'd1, 1'b1);
      tick(50);
      acq_done  = 1'b1;
      start     = 1'b1;
      step_mask = 4'b1111;
      @(negedge clk);
      acq_done = 1'b0;
      start    = 1'b0;
      check("t5_settle_kept", state_o, ST_SETTLE);
      check("t5_no_req", acq_req_o, 0);
      check("t5_sel_kept", meas_sel_o, MEAS_VX);
      tick(3);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("t5_abort_state", state_o, ST_PARK);
      check("t5_abort_sel", meas_sel_o, MEAS_GND);
      check("t5_abort_bias", bias_on_o, 0);
      check("t5_abort_busy", busy_o, 1);
      wait_idle(c);
      check("t5_park_len", c, SETTLE);
      check("t5_no_done", done_cnt - d0, 0);
      check("t5_no_req_rise", req_rise - r0, 0);
      check("t5_err", err_o, 0);
      tick(2);

      // 5b: abort coincident with acq_done
      d0 = done_cnt;
      start_seq(4'b0011, 3'd4, 2'd3, 1'b1);
      wait_req(c);
      check("t5b_req_latency", c, SETTLE + 1);
      tick(3);
      acq_done = 1'b1;
      abort    = 1'b1;
      @(negedge clk);
      acq_done = 1'b0;
      abort    = 1'b0;
      check("t5b_req_drop", acq_req_o, 0);
      check("t5b_state", state_o, ST_PARK);
      @(negedge clk);
      check("t5b_sel", meas_sel_o, MEAS_GND);
      wait_idle(c);
      check("t5b_park_len", c, SETTLE - 1);
      check("t5b_no_done", done_cnt - d0, 0);
      check("t5b_err", err_o, 0);
      tick(2);

      // 6: asynchronous reset in ACQ_WAIT
      start_seq(4'b0100, 3'd3, 2'd2, 1'b1);
      check("t6_sel", meas_sel_o, MEAS_LP);
      wait_req(c);
      check("t6_req_latency", c, SETTLE + 1);
      tick(4);
      rst_n = 1'b0;
      #1;
      check("t6_req", acq_req_o, 0);
      check("t6_sel_gnd", meas_sel_o, MEAS_GND);
      check("t6_busy", busy_o, 0);
      check("t6_idx", step_idx_o, 0);
      check("t6_rr", rr_sel_o, 0);
      check("t6_bias", bias_on_o, 0);
      check("t6_state", state_o, ST_IDLE);
      @(negedge clk);
      rst_n = 1'b1;
      tick(3);
      check("t6_idle_after", busy_o, 0);
      check("t6_no_done", done_o, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
